// File: rtl/servo_pulse_decoder_pkg.sv
// Shared servo timing constants, FSM encodings and the position helper.
// Latency: n/a (declarations only). Backpressure: n/a.
// Values match the PWM generator so a loopback reproduces the control code.
package servo_pulse_decoder_pkg;

    localparam int SERVO_MIN_PULSE = 70000;
    localparam int SERVO_MAX_PULSE = 250000;
    localparam int SERVO_TIMEOUT   = 4000000;

    typedef logic [21:0] width_t;
    typedef logic [17:0] pos_t;

    localparam logic [1:0] ST_SYNC  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_HIGH  = 2'd2;

    // Only called on widths already known to be >= min_w, so never underflows.
    function automatic pos_t to_position(input width_t w, input width_t min_w);
        width_t diff;
        diff = w - min_w;
        return diff[17:0];
    endfunction

endpackage

// File: rtl/servo_pulse_decoder_if.sv
// Pulse input and decoded result bundle between the pin side and servo control.
// Latency: n/a (wires only). Backpressure: none, results are strobes/levels.
// master = decoder, slave = consumer/stimulus driving the pin.
interface servo_pulse_decoder_if;
    import servo_pulse_decoder_pkg::*;

    logic   pwm_in;
    width_t pulse_width;
    pos_t   position;
    logic   pulse_valid;
    logic   pulse_err;
    logic   signal_lost;

    modport master (
        input  pwm_in,
        output pulse_width, position, pulse_valid, pulse_err, signal_lost
    );

    modport slave (
        output pwm_in,
        input  pulse_width, position, pulse_valid, pulse_err, signal_lost
    );

endinterface

// File: rtl/servo_pulse_decoder_sync_ff.sv
// Multi-flop synchronizer for the asynchronous pulse pin, resets to 1.
// Latency: STAGES cycles. Backpressure: none.
// Reset value 1 makes the decoder treat the line as mid-pulse until it drops.
module servo_pulse_decoder_sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clock) begin
        if (reset) begin
            ff <= '1;
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/servo_pulse_decoder.sv
// Measures servo pulse high time, validates it and recovers the position code.
// Latency: pin fall -> pulse_valid/pulse_err = SYNC_STAGES+2 cycles, constant.
// Backpressure: none; results are one-cycle strobes with held width/position.
module servo_pulse_decoder
    import servo_pulse_decoder_pkg::*;
#(
    parameter int MIN_PULSE   = SERVO_MIN_PULSE,
    parameter int MAX_PULSE   = SERVO_MAX_PULSE,
    parameter int TIMEOUT     = SERVO_TIMEOUT,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    servo_pulse_decoder_if.master bus
);

    localparam width_t MIN_W = width_t'(MIN_PULSE);
    localparam width_t MAX_W = width_t'(MAX_PULSE);
    localparam width_t TO_W  = width_t'(TIMEOUT);

    logic       s_in;
    logic       s_prev;
    logic       rise;
    logic       fall;
    logic [1:0] state;
    width_t     high_cnt;
    width_t     lost_cnt;
    width_t     pend_cnt;
    logic       pend_ok;
    logic       pend_err;

    servo_pulse_decoder_sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
        .clock (clock),
        .reset (reset),
        .d     (bus.pwm_in),
        .q     (s_in)
    );

    assign rise = s_in & ~s_prev;
    assign fall = ~s_in & s_prev;

    always_ff @(posedge clock) begin
        if (reset) begin
            s_prev          <= 1'b1;
            state           <= ST_SYNC;
            high_cnt        <= '0;
            lost_cnt        <= '0;
            pend_cnt        <= '0;
            pend_ok         <= 1'b0;
            pend_err        <= 1'b0;
            bus.pulse_width <= '0;
            bus.position    <= '0;
            bus.pulse_valid <= 1'b0;
            bus.pulse_err   <= 1'b0;
            bus.signal_lost <= 1'b0;
        end else begin
            s_prev   <= s_in;
            pend_ok  <= 1'b0;
            pend_err <= 1'b0;

            case (state)
                ST_SYNC: begin
                    if (!s_in) state <= ST_ARMED;
                end
                ST_ARMED: begin
                    if (rise) begin
                        state    <= ST_HIGH;
                        high_cnt <= width_t'(1);
                    end
                end
                ST_HIGH: begin
                    if (fall) begin
                        state <= ST_ARMED;
                        if (high_cnt >= MIN_W && high_cnt <= MAX_W) begin
                            pend_ok  <= 1'b1;
                            pend_cnt <= high_cnt;
                        end else begin
                            pend_err <= 1'b1;
                        end
                    end else if (high_cnt > MAX_W) begin
                        // Overlong pulse: report once, then wait for the line to drop.
                        pend_err <= 1'b1;
                        state    <= ST_SYNC;
                    end else begin
                        high_cnt <= high_cnt + width_t'(1);
                    end
                end
                default: state <= ST_SYNC;
            endcase

            if (rise) begin
                lost_cnt <= '0;
            end else if (lost_cnt != TO_W) begin
                lost_cnt <= lost_cnt + width_t'(1);
            end

            // A rising edge in the same cycle as the timeout suppresses the loss flag.
            if (!rise && lost_cnt == TO_W - width_t'(1)) begin
                bus.signal_lost <= 1'b1;
            end else if (pend_ok) begin
                bus.signal_lost <= 1'b0;
            end

            bus.pulse_valid <= pend_ok;
            bus.pulse_err   <= pend_err;
            if (pend_ok) begin
                bus.pulse_width <= pend_cnt;
                bus.position    <= to_position(pend_cnt, MIN_W);
            end
        end
    end

endmodule

// File: tb/tb_servo_pulse_decoder.sv
// Directed bench for servo_pulse_decoder with time-scaled pulse limits.
// Limits: MIN 70, MAX 250, TIMEOUT 4000 cycles, 2 synchronizer stages.
module tb_servo_pulse_decoder;

    localparam int MINP = 70;
    localparam int MAXP = 250;
    localparam int TOUT = 4000;
    localparam int LAT  = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;

    int checks   = 0;
    int failures = 0;
    int n        = 0;
    int nv       = 0;
    int ne       = 0;
    int lat      = -1;
    int both     = 0;

    servo_pulse_decoder_if bus_if ();

    servo_pulse_decoder #(
        .MIN_PULSE   (MINP),
        .MAX_PULSE   (MAXP),
        .TIMEOUT     (TOUT),
        .SYNC_STAGES (2)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if.master)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clr_marks();
        n   = 0;
        nv  = 0;
        ne  = 0;
        lat = -1;
    endtask

    task automatic hold(input logic level, input int cycles);
        bus_if.pwm_in = level;
        for (int i = 0; i < cycles; i++) begin
            tick();
            n++;
            if (bus_if.pulse_valid === 1'b1) begin
                nv++;
                if (lat < 0) lat = n;
            end
            if (bus_if.pulse_err === 1'b1) begin
                ne++;
                if (lat < 0) lat = n;
            end
            if (bus_if.pulse_valid === 1'b1 && bus_if.pulse_err === 1'b1) both++;
        end
    endtask

    task automatic run_pulse(input int hi);
        clr_marks();
        hold(1'b1, hi);
        n   = 0;
        lat = -1;
        hold(1'b0, 40);
    endtask

    task automatic legal(input int hi);
        run_pulse(hi);
        chk($sformatf("valid_cnt_%0d", hi), nv, 1);
        chk($sformatf("err_cnt_%0d", hi), ne, 0);
        chk($sformatf("latency_%0d", hi), lat, LAT);
        chk($sformatf("width_%0d", hi), 32'(bus_if.pulse_width), hi);
        chk($sformatf("position_%0d", hi), 32'(bus_if.position), hi - MINP);
    endtask

    task automatic illegal(input int hi, input int prev);
        run_pulse(hi);
        chk($sformatf("err_cnt_%0d", hi), ne, 1);
        chk($sformatf("valid_cnt_%0d", hi), nv, 0);
        chk($sformatf("err_latency_%0d", hi), lat, LAT);
        chk($sformatf("width_hold_%0d", hi), 32'(bus_if.pulse_width), prev);
        chk($sformatf("position_hold_%0d", hi), 32'(bus_if.position), prev - MINP);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_width"}, 32'(bus_if.pulse_width), 0);
        chk({tag, "_position"}, 32'(bus_if.position), 0);
        chk({tag, "_valid"}, 32'(bus_if.pulse_valid), 0);
        chk({tag, "_err"}, 32'(bus_if.pulse_err), 0);
        chk({tag, "_lost"}, 32'(bus_if.signal_lost), 0);
    endtask

    initial begin
        bus_if.pwm_in = 1'b0;
        reset = 1'b1;
        repeat (3) tick();
        chk_zero("reset");
        reset = 1'b0;
        hold(1'b0, 10);

        // Minimum-width frames, then mid-scale positions.
        legal(70);
        legal(70);
        legal(120);
        legal(220);

        // Just outside both limits is rejected; the upper limit itself is legal.
        illegal(69, 220);
        illegal(251, 220);
        legal(250);

        // Reset released mid-pulse: that pulse must be ignored.
        reset = 1'b1;
        bus_if.pwm_in = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        chk_zero("midpulse_reset");
        clr_marks();
        hold(1'b1, 50);
        hold(1'b0, 40);
        chk("partial_valid", nv, 0);
        chk("partial_err", ne, 0);

        // Full pulse of 100, then hold low to the timeout counted from its rise.
        clr_marks();
        hold(1'b1, 100);
        hold(1'b0, TOUT + 2 - 100);
        chk("p100_valid", nv, 1);
        chk("p100_position", 32'(bus_if.position), 30);
        chk("lost_before_timeout", 32'(bus_if.signal_lost), 0);
        hold(1'b0, 1);
        chk("lost_at_timeout", 32'(bus_if.signal_lost), 1);
        chk("lost_width_hold", 32'(bus_if.pulse_width), 100);

        // Legal pulse clears the loss; next rise lands exactly on the timeout.
        clr_marks();
        hold(1'b1, 70);
        hold(1'b0, TOUT - 70);
        chk("recover_valid", nv, 1);
        chk("recover_lost_clear", 32'(bus_if.signal_lost), 0);
        hold(1'b1, 80);
        chk("edge_wins_lost", 32'(bus_if.signal_lost), 0);
        hold(1'b0, 40);
        chk("edge_wins_valid", nv, 2);
        chk("edge_wins_position", 32'(bus_if.position), 10);

        // One-cycle reset during a high phase.
        clr_marks();
        hold(1'b1, 50);
        reset = 1'b1;
        tick();
        chk_zero("reset_in_high");
        reset = 1'b0;
        hold(1'b1, 50);
        hold(1'b0, 40);
        chk("resync_valid", nv, 0);
        chk("resync_err", ne, 0);
        legal(90);

        // Stuck-high line: one error, then loss after the timeout from the rise.
        clr_marks();
        hold(1'b1, TOUT + 2);
        chk("stuck_err_cnt", ne, 1);
        chk("stuck_valid_cnt", nv, 0);
        chk("stuck_lost_before", 32'(bus_if.signal_lost), 0);
        hold(1'b1, 1);
        chk("stuck_lost_at", 32'(bus_if.signal_lost), 1);
        chk("stuck_width_hold", 32'(bus_if.pulse_width), 90);
        chk("stuck_position_hold", 32'(bus_if.position), 20);

        chk("valid_err_exclusive", both, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
